// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between ALU and LSU result ports, one
// registered register-file write stage, read-port forwarding, contention counter.
module wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              lsu_ready_o,
  output logic [ADDR_W-1:0] addrrd_o,
  output logic [DATA_W-1:0] datord_o,
  output logic              writeen_o,
  input  logic [ADDR_W-1:0] addrs1_i,
  input  logic [ADDR_W-1:0] addrs2_i,
  input  logic [DATA_W-1:0] regrs1_i,
  input  logic [DATA_W-1:0] regrs2_i,
  output logic [DATA_W-1:0] dators1_o,
  output logic [DATA_W-1:0] dators2_o,
  output logic [15:0]       conflicts_o
);

  localparam int unsigned CNT_W = 16;

  logic              r_last_lsu;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_conflicts;

  logic              w_grant_alu;
  logic              w_grant_lsu;
  logic              w_contend;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_fwd1;
  logic              w_fwd2;

  // Under contention the side that did not win last time gets the grant;
  // reset suppresses both grants immediately.
  always_comb begin
    w_contend   = alu_valid_i & lsu_valid_i;
    w_grant_alu = 1'b0;
    w_grant_lsu = 1'b0;
    if (!rst_i) begin
      if (w_contend) begin
        w_grant_alu = r_last_lsu;
        w_grant_lsu = ~r_last_lsu;
      end else begin
        w_grant_alu = alu_valid_i;
        w_grant_lsu = lsu_valid_i;
      end
    end
    w_addr = w_grant_lsu ? lsu_addr_i : alu_addr_i;
    w_data = w_grant_lsu ? lsu_data_i : alu_data_i;
  end

  assign alu_ready_o = w_grant_alu;
  assign lsu_ready_o = w_grant_lsu;

  // Round-robin flag, output stage and saturating contention counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_lsu  <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_conflicts <= '0;
    end else begin
      if (w_grant_alu || w_grant_lsu) begin
        r_last_lsu <= w_grant_lsu;
        r_addr     <= w_addr;
        r_data     <= w_data;
        r_we       <= (w_addr != '0);
      end else begin
        r_we <= 1'b0;
      end
      if (w_contend && (r_conflicts != {CNT_W{1'b1}})) begin
        r_conflicts <= r_conflicts + CNT_W'(1);
      end
    end
  end

  assign writeen_o   = r_we;
  assign addrrd_o    = r_addr;
  assign datord_o    = r_data;
  assign conflicts_o = r_conflicts;

  // Bypass the write in flight to matching read ports; register 0 never forwards.
  always_comb begin
    w_fwd1    = r_we && (r_addr == addrs1_i) && (addrs1_i != '0);
    w_fwd2    = r_we && (r_addr == addrs2_i) && (addrs2_i != '0);
    dators1_o = w_fwd1 ? r_data : regrs1_i;
    dators2_o = w_fwd2 ? r_data : regrs2_i;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width (32 registers).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port alu_valid_i  input  1  ALU writeback request.
REQ-006 The block SHALL have port alu_addr_i  input  ADDR_W  ALU destination register.
REQ-007 The block SHALL have port alu_data_i  input  DATA_W  ALU result.
REQ-008 The block SHALL have port alu_ready_o  output  1  ALU request accepted this cycle.
REQ-009 The block SHALL have port lsu_valid_i  input  1  load-unit writeback request.
REQ-010 The block SHALL have port lsu_addr_i  input  ADDR_W  load destination register.
REQ-011 The block SHALL have port lsu_data_i  input  DATA_W  load data.
REQ-012 The block SHALL have port lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-013 The block SHALL have port addrrd_o  output  ADDR_W  register-file write address.
REQ-014 The block SHALL have port datord_o  output  DATA_W  register-file write data.
REQ-015 The block SHALL have port writeen_o  output  1  register-file write enable.
REQ-016 The block SHALL have ports addrs1_i, addrs2_i  input  ADDR_W  register-file read addresses, also driven to the register file.
REQ-017 The block SHALL have ports regrs1_i, regrs2_i  input  DATA_W  raw register-file read data.
REQ-018 The block SHALL have ports dators1_o, dators2_o  output  DATA_W  forwarded read data.
REQ-019 The block SHALL have port conflicts_o  output  16  saturating count of contended cycles.

Function
REQ-020 Grant SHALL be combinational: only one valid -> that requester is granted; neither valid -> no grant; ready_o = grant for each requester.
REQ-021 Both valid SHALL grant the requester not granted most recently (1-bit round-robin flag last_lsu); after reset last_lsu=1, so ALU wins the first contention.
REQ-022 last_lsu SHALL update only on a grant: 1 on LSU grant, 0 on ALU grant.
REQ-023 A granted request SHALL be registered into the output stage: addrrd_o/datord_o load the granted addr/data at the next edge; latency exactly 1 cycle.
REQ-024 writeen_o SHALL be 1 for exactly one cycle per granted request whose addr != 0.
REQ-025 A granted request with addr == 0 SHALL be accepted (ready_o=1, round-robin updates) but SHALL leave writeen_o=0.
REQ-026 No grant in a cycle SHALL give writeen_o=0 next cycle; addrrd_o/datord_o hold their previous values.
REQ-027 dators1_o SHALL equal datord_o when writeen_o=1 and addrrd_o == addrs1_i and addrs1_i != 0, otherwise regrs1_i; dators2_o likewise with addrs2_i/regrs2_i; purely combinational.
REQ-028 conflicts_o SHALL increment by 1 on each edge where alu_valid_i and lsu_valid_i are both 1, and saturate at 16'hFFFF.
REQ-029 The block SHALL never assert both alu_ready_o and lsu_ready_o in the same cycle.
REQ-030 The block SHALL never drop an accepted request; a non-granted requester holds valid/addr/data until granted.

Reset
REQ-031 While rst_i=1: writeen_o=0, addrrd_o=0, datord_o=0, conflicts_o=0, last_lsu=1, alu_ready_o=lsu_ready_o=0; effect immediate, independent of clk_i.
REQ-032 A request presented on the edge where rst_i is asserted SHALL be discarded; the write in the output stage at that moment SHALL be cancelled (writeen_o forced 0).
REQ-033 After deassertion, the first edge SHALL behave as a normal arbitration cycle.

Verification
REQ-034 ALU only, addr=5, data=32'hDEADBEEF -> alu_ready_o=1 same cycle; next cycle writeen_o=1, addrrd_o=5, datord_o=32'hDEADBEEF.
REQ-035 Both valid for 3 consecutive cycles with fresh requests each cycle -> grants ALU, LSU, ALU; conflicts_o=3.
REQ-036 LSU only, addr=0, data=32'h1 -> lsu_ready_o=1; next cycle writeen_o=0.
REQ-037 Output stage writing addr=7, data=32'hA5A5A5A5 while addrs1_i=7, regrs1_i=32'h0 -> dators1_o=32'hA5A5A5A5; with addrs2_i=8 -> dators2_o=regrs2_i.
REQ-038 rst_i pulsed mid-cycle while writeen_o=1 -> writeen_o drops immediately; conflicts_o=0; next contention grants ALU.
REQ-039 Hold both valid for 70000 cycles -> conflicts_o stays at 16'hFFFF.
